// File: rtl/count_seq_checker.sv
// Sequence monitor for a free-running counter: checks each sample is the previous +1,
// locks after a run of clean increments, then counts locked wraps and sequence errors.
module count_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_LEN = 4,
    parameter int WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  count,
    input  logic              clr,
    output logic              locked,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              err_pulse,
    output logic [7:0]        err_cnt,
    output logic              sticky_err
);

    typedef enum logic {
        ACQUIRE = 1'b0,
        LOCKED  = 1'b1
    } state_t;

    localparam logic [3:0]        LOCK_TGT  = 4'(LOCK_LEN);
    localparam logic [WIDTH-1:0]  CNT_ONE   = WIDTH'(1);
    localparam logic [WRAP_W-1:0] WRAP_ONE  = WRAP_W'(1);

    state_t           state;
    logic [WIDTH-1:0] prev_q;
    logic             prev_valid;
    logic [3:0]       good_cnt;

    logic [WIDTH-1:0] expected;
    logic [3:0]       good_inc;
    logic             ok;
    logic             is_wrap;

    always_comb begin
        expected = prev_q + CNT_ONE;
        good_inc = good_cnt + 4'd1;
        ok       = prev_valid && (count == expected);
        is_wrap  = (prev_q == {WIDTH{1'b1}}) && (count == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACQUIRE;
            prev_q     <= '0;
            prev_valid <= 1'b0;
            good_cnt   <= '0;
            locked     <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            err_pulse  <= 1'b0;
            err_cnt    <= '0;
            sticky_err <= 1'b0;
        end else begin
            // Every sample becomes the reference, including an offending one.
            prev_q     <= count;
            prev_valid <= 1'b1;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;

            case (state)
                ACQUIRE: begin
                    if (ok) begin
                        if (good_inc == LOCK_TGT) begin
                            state    <= LOCKED;
                            locked   <= 1'b1;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_inc;
                        end
                    end else begin
                        good_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (ok) begin
                        if (is_wrap) begin
                            wrap_pulse <= 1'b1;
                            wrap_cnt   <= wrap_cnt + WRAP_ONE;
                        end
                    end else begin
                        err_pulse  <= 1'b1;
                        sticky_err <= 1'b1;
                        if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        state      <= ACQUIRE;
                        locked     <= 1'b0;
                        good_cnt   <= '0;
                    end
                end
                default: begin
                    state  <= ACQUIRE;
                    locked <= 1'b0;
                end
            endcase

            // Pulses still fire on a clr edge; only the statistics are wiped.
            if (clr) begin
                wrap_cnt   <= '0;
                err_cnt    <= '0;
                sticky_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_count_seq_checker.sv
// Table-driven bench for count_seq_checker: each record holds the inputs for one edge
// and the outputs required after that edge.
module tb_count_seq_checker;

    typedef struct {
        int         sec;
        logic       rst;
        logic       clr;
        logic [3:0] cnt;
        logic       lk;
        logic       wp;
        logic [7:0] wc;
        logic       ep;
        logic [7:0] ec;
        logic       st;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] count = '0;
    logic       clr = 1'b0;
    logic       locked;
    logic       wrap_pulse;
    logic [7:0] wrap_cnt;
    logic       err_pulse;
    logic [7:0] err_cnt;
    logic       sticky_err;

    vec_t vec_q[$];
    int   applied = 0;
    int   miscompares = 0;
    int   cur_sec = 0;

    count_seq_checker #(.WIDTH(4), .LOCK_LEN(4), .WRAP_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .count      (count),
        .clr        (clr),
        .locked     (locked),
        .wrap_pulse (wrap_pulse),
        .wrap_cnt   (wrap_cnt),
        .err_pulse  (err_pulse),
        .err_cnt    (err_cnt),
        .sticky_err (sticky_err)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic c, input logic [3:0] cv,
                       input logic lk, input logic wp, input logic [7:0] wc,
                       input logic ep, input logic [7:0] ec, input logic st);
        vec_t v;
        v.sec = cur_sec; v.rst = r; v.clr = c; v.cnt = cv;
        v.lk = lk; v.wp = wp; v.wc = wc; v.ep = ep; v.ec = ec; v.st = st;
        vec_q.push_back(v);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst   = v.rst;
        clr   = v.clr;
        count = v.cnt;
        @(posedge clk);
        #1;
        applied++;
        if (locked !== v.lk || wrap_pulse !== v.wp || wrap_cnt !== v.wc ||
            err_pulse !== v.ep || err_cnt !== v.ec || sticky_err !== v.st) begin
            miscompares++;
            $display("FAIL sec%0d vec%0d cnt=%0d: got lk=%b wp=%b wc=%0d ep=%b ec=%0d st=%b, want lk=%b wp=%b wc=%0d ep=%b ec=%0d st=%b",
                     v.sec, idx, v.cnt, locked, wrap_pulse, wrap_cnt, err_pulse, err_cnt, sticky_err,
                     v.lk, v.wp, v.wc, v.ep, v.ec, v.st);
        end
    endtask

    initial begin
        logic [3:0] v;
        logic [3:0] e;
        logic [7:0] ec;

        // Reset held for 3 cycles with a random count.
        cur_sec = 1;
        for (int i = 0; i < 3; i++) add(1, 0, 4'($urandom_range(0, 15)), 0, 0, 0, 0, 0, 0);

        // Clean ramp: lock after the 5th sample, wrap on every 15->0 while locked.
        cur_sec = 2;
        for (int i = 0; i <= 52; i++)
            add(0, 0, 4'(i), i >= 4, (i > 0) && (i % 16 == 0), 8'(i / 16), 0, 0, 0);
        add(0, 0, 5, 1, 0, 3, 0, 0, 0);

        // Skip 5 -> 7: one error, re-lock on the sample 11.
        cur_sec = 3;
        add(0, 0, 7, 0, 0, 3, 1, 1, 1);
        add(0, 0, 8, 0, 0, 3, 0, 1, 1);
        add(0, 0, 9, 0, 0, 3, 0, 1, 1);
        add(0, 0, 10, 0, 0, 3, 0, 1, 1);
        add(0, 0, 11, 1, 0, 3, 0, 1, 1);
        for (int i = 12; i <= 15; i++) add(0, 0, 4'(i), 1, 0, 3, 0, 1, 1);
        add(0, 0, 0, 1, 1, 4, 0, 1, 1);
        for (int i = 1; i <= 9; i++) add(0, 0, 4'(i), 1, 0, 4, 0, 1, 1);

        // Stall at 9 for 3 extra cycles: exactly one error, re-lock on 13.
        cur_sec = 4;
        add(0, 0, 9, 0, 0, 4, 1, 2, 1);
        add(0, 0, 9, 0, 0, 4, 0, 2, 1);
        add(0, 0, 9, 0, 0, 4, 0, 2, 1);
        add(0, 0, 10, 0, 0, 4, 0, 2, 1);
        add(0, 0, 11, 0, 0, 4, 0, 2, 1);
        add(0, 0, 12, 0, 0, 4, 0, 2, 1);
        add(0, 0, 13, 1, 0, 4, 0, 2, 1);
        add(0, 0, 14, 1, 0, 4, 0, 2, 1);
        add(0, 0, 15, 1, 0, 4, 0, 2, 1);
        add(0, 0, 0, 1, 1, 5, 0, 2, 1);
        for (int i = 1; i <= 15; i++) add(0, 0, 4'(i), 1, 0, 5, 0, 2, 1);

        // clr on a locked wrap, then clr on an error edge.
        cur_sec = 5;
        add(0, 1, 0, 1, 1, 0, 0, 0, 0);
        add(0, 0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 5, 0, 0, 0, 1, 0, 0);
        add(0, 0, 6, 0, 0, 0, 0, 0, 0);
        add(0, 0, 7, 0, 0, 0, 0, 0, 0);
        add(0, 0, 8, 0, 0, 0, 0, 0, 0);
        add(0, 0, 9, 1, 0, 0, 0, 0, 0);
        add(0, 0, 10, 1, 0, 0, 0, 0, 0);

        // 260 lock/skip rounds: err_cnt saturates at 255, pulses keep firing.
        cur_sec = 6;
        v = 4'd10;
        for (int n = 0; n < 260; n++) begin
            e  = v + 4'd2;
            ec = (n + 1 > 255) ? 8'd255 : 8'(n + 1);
            add(0, 0, e, 0, 0, 0, 1, ec, 1);
            add(0, 0, e + 4'd1, 0, 0, 0, 0, ec, 1);
            add(0, 0, e + 4'd2, 0, 0, 0, 0, ec, 1);
            add(0, 0, e + 4'd3, 0, 0, 0, 0, ec, 1);
            add(0, 0, e + 4'd4, 1, 0, 0, 0, ec, 1);
            v = e + 4'd4;
        end

        // Mid-run reset while locked, then the normal lock latency.
        cur_sec = 7;
        add(1, 1, 4'($urandom_range(0, 15)), 0, 0, 0, 0, 0, 0);
        add(0, 0, 3, 0, 0, 0, 0, 0, 0);
        add(0, 0, 4, 0, 0, 0, 0, 0, 0);
        add(0, 0, 5, 0, 0, 0, 0, 0, 0);
        add(0, 0, 6, 0, 0, 0, 0, 0, 0);
        add(0, 0, 7, 1, 0, 0, 0, 0, 0);
        add(0, 0, 8, 1, 0, 0, 0, 0, 0);

        // Upstream held in reset: count stuck at 0 never locks and never errors.
        cur_sec = 8;
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vec_q.size(); i++) apply(vec_q[i], i);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
